// File: rtl/key_mux_pipe.sv
// Programmable key->data lookup table with priority match and a single flow-controlled output register.
// Optional KEY_MUX_STATS_EN adds saturating hit/miss counters (hit_cnt, miss_cnt).
module key_mux_pipe #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 2,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(NR_KEY)-1:0] cfg_idx,
    input  logic [KEY_LEN-1:0]        cfg_key,
    input  logic [DATA_LEN-1:0]       cfg_data,
    input  logic                      cfg_clr,
    input  logic [DATA_LEN-1:0]       default_out,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KEY_LEN-1:0]        in_key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic                      out_hit
`ifdef KEY_MUX_STATS_EN
    ,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NR_KEY);

    // Miss result: the sampled default word, or zero when defaults are disabled.
    function automatic logic [DATA_LEN-1:0] miss_value(input logic [DATA_LEN-1:0] dflt);
        return (HAS_DEFAULT != 0) ? dflt : '0;
    endfunction

    logic [NR_KEY-1:0]   r_ent_vld;
    logic [KEY_LEN-1:0]  r_ent_key  [NR_KEY];
    logic [DATA_LEN-1:0] r_ent_data [NR_KEY];

    logic                w_accept;
    logic                w_hit_p0;
    logic [DATA_LEN-1:0] w_hit_data_p0;
    logic [DATA_LEN-1:0] w_res_data_p0;

    logic                r_vld_p1;
    logic [DATA_LEN-1:0] r_data_p1;
    logic                r_hit_p1;

    // Valid bits: a write in the same cycle as a clear survives the clear.
    // Out-of-range indices never match any i, so such writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent_vld <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    r_ent_vld[i] <= 1'b1;
                end else if (cfg_clr) begin
                    r_ent_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_KEY; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                r_ent_key[i]  <= cfg_key;
                r_ent_data[i] <= cfg_data;
            end
        end
    end

    // ---- p0: lookup against the pre-write table ----
    always_comb begin
        w_hit_p0      = 1'b0;
        w_hit_data_p0 = '0;
        // Scan high to low so the lowest matching index is the final assignment.
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (r_ent_vld[i] && (r_ent_key[i] == in_key)) begin
                w_hit_p0      = 1'b1;
                w_hit_data_p0 = r_ent_data[i];
            end
        end
    end

    assign w_res_data_p0 = w_hit_p0 ? w_hit_data_p0 : miss_value(default_out);

    assign in_ready = !r_vld_p1 || out_ready;
    assign w_accept = in_valid && in_ready;

    // ---- p1: output register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_hit_p1  <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_res_data_p0;
            r_hit_p1  <= w_hit_p0;
        end else if (out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_hit   = r_hit_p1;

`ifdef KEY_MUX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Clear takes precedence over a lookup counted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (cfg_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit_p0) begin
                r_hit_cnt  <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_key_mux_pipe.sv
// Directed bench for key_mux_pipe: defaults, priority, write/lookup ordering, stall, clear and reset.
module tb_key_mux_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [1:0] cfg_key;
    logic [7:0] cfg_data;
    logic       cfg_clr;
    logic [7:0] default_out;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_key;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_hit;
`ifdef KEY_MUX_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_mux_pipe #(
        .NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data),
        .cfg_clr(cfg_clr), .default_out(default_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_hit(out_hit)
`ifdef KEY_MUX_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [1:0] key, input logic [7:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_key = key; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [1:0] key,
                          input logic hit_e, input logic [7:0] data_e);
        in_valid = 1'b1; in_key = key;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_hit"},   32'(out_hit),   32'(hit_e));
        check({tag, "_data"},  32'(out_data),  32'(data_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0;
        cfg_clr = 1'b0; default_out = 8'hA5; in_valid = 1'b0; in_key = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data),  0);
        check("rst_hit",   32'(out_hit),   0);
`ifdef KEY_MUX_STATS_EN
        check("rst_hitcnt",  32'(hit_cnt),  0);
        check("rst_misscnt", 32'(miss_cnt), 0);
`endif
        rst_n = 1'b1;
        tick();

        // Empty table: miss returns default
        lookup("t1", 2'b01, 1'b0, 8'hA5);
        tick();
        check("t1_drain_valid", 32'(out_valid), 0);
        check("t1_drain_data",  32'(out_data),  'hA5);

        wr(2'd0, 2'b10, 8'h3C);
        lookup("t2", 2'b10, 1'b1, 8'h3C);

        // Lowest index wins on duplicate keys
        wr(2'd1, 2'b11, 8'h11);
        wr(2'd3, 2'b11, 8'h22);
        lookup("t3", 2'b11, 1'b1, 8'h11);

        // Write and lookup in the same cycle: lookup sees the old table
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_key = 2'b00; cfg_data = 8'h77;
        lookup("t4a", 2'b00, 1'b0, 8'hA5);
        cfg_we = 1'b0;
        lookup("t4b", 2'b00, 1'b1, 8'h77);

        tick();
        check("t4_drain_valid", 32'(out_valid), 0);
        check("t4_drain_data",  32'(out_data),  'h77);

        // Stall for 3 cycles, then release into back-to-back results
        out_ready = 1'b0; in_valid = 1'b1; in_key = 2'b10;
        tick();
        check("t5_first_valid", 32'(out_valid), 1);
        check("t5_first_data",  32'(out_data),  'h3C);
        in_key = 2'b11;
        for (int i = 0; i < 3; i++) begin
            check("t5_stall_ready", 32'(in_ready), 0);
            check("t5_stall_data",  32'(out_data), 'h3C);
            check("t5_stall_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t5_release_ready", 32'(in_ready), 1);
        tick();
        check("t5_second_data", 32'(out_data), 'h11);
        check("t5_second_hit",  32'(out_hit),  1);
        in_key = 2'b00;
        tick();
        check("t5_third_data",  32'(out_data),  'h77);
        check("t5_third_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        check("t5_end_valid", 32'(out_valid), 0);
        check("t5_end_data",  32'(out_data),  'h77);

        // Clear and write together: only the written entry survives
        cfg_clr = 1'b1;
        wr(2'd1, 2'b01, 8'h55);
        cfg_clr = 1'b0;
        lookup("t6a", 2'b11, 1'b0, 8'hA5);
        lookup("t6b", 2'b01, 1'b1, 8'h55);
        default_out = 8'h5A;
        lookup("t6c", 2'b10, 1'b0, 8'h5A);
        default_out = 8'hA5;

        // Asynchronous reset mid-stream
        wr(2'd0, 2'b10, 8'h3C);
        lookup("t7pre", 2'b10, 1'b1, 8'h3C);
        in_valid = 1'b1; in_key = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(out_valid), 0);
        check("t7_rst_data",  32'(out_data),  0);
        check("t7_rst_hit",   32'(out_hit),   0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_idle_valid", 32'(out_valid), 0);
        lookup("t7a", 2'b10, 1'b0, 8'hA5);
        lookup("t7b", 2'b01, 1'b0, 8'hA5);
        lookup("t7c", 2'b00, 1'b0, 8'hA5);
`ifdef KEY_MUX_STATS_EN
        check("t7_misscnt", 32'(miss_cnt), 3);
        check("t7_hitcnt",  32'(hit_cnt),  0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
